// File: rtl/conv_encoder_param_if.sv
// Bit-serial stream bundle with valid/ready flow control and a frame-end marker.
// The same interface carries the information bits (W=1) and the coded symbols (W=N).
interface conv_encoder_param_if #(
    parameter int W = 1
);
    logic         valid;
    logic [W-1:0] data;
    logic         last;
    logic         ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/conv_encoder_param.sv
// Rate-1/N feed-forward convolutional encoder, constraint length K, with valid/ready
// on both sides and optional zero-tail termination so every frame ends in state 0.
module conv_encoder_param #(
    parameter int               K    = 3,
    parameter int               N    = 2,
    parameter logic [N*K-1:0]   G    = {3'b101, 3'b111},
    parameter int               TERM = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conv_encoder_param_if.slave   info,
    conv_encoder_param_if.master  code
);
    localparam int CW = $clog2(K);

    typedef enum logic {RUN, TAIL} state_t;

    state_t         state_reg;
    logic [K-2:0]   sr_reg;
    logic [CW-1:0]  tail_cnt_reg;
    logic           valid_reg;
    logic           last_reg;
    logic [N-1:0]   data_reg;

    logic           slot;
    logic           in_fire;
    logic           tail_step;
    logic           tail_final;
    logic           in_bit;
    logic [K-1:0]   window;
    logic [N-1:0]   sym_next;

    // A symbol slot is free when the output register is empty or being drained this cycle.
    assign slot       = ~valid_reg | code.ready;
    assign info.ready = (state_reg == RUN) & slot;
    assign in_fire    = info.valid & info.ready;
    assign tail_step  = (state_reg == TAIL) & slot;
    assign tail_final = (tail_cnt_reg == CW'(1));

    // Tail slots push zeros through the window to flush the memory back to 0.
    assign in_bit = (state_reg == RUN) ? info.data[0] : 1'b0;
    assign window = {sr_reg, in_bit};

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_parity
            assign sym_next[gi] = ^(window & G[gi*K +: K]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            sr_reg       <= '0;
            tail_cnt_reg <= '0;
            valid_reg    <= 1'b0;
            last_reg     <= 1'b0;
            data_reg     <= '0;
        end else if (in_fire) begin
            valid_reg <= 1'b1;
            data_reg  <= sym_next;
            sr_reg    <= window[K-2:0];
            if ((TERM != 0) && info.last) begin
                state_reg    <= TAIL;
                tail_cnt_reg <= CW'(K - 1);
                last_reg     <= 1'b0;
            end else begin
                last_reg <= (TERM == 0) ? info.last : 1'b0;
            end
        end else if (tail_step) begin
            valid_reg    <= 1'b1;
            data_reg     <= sym_next;
            sr_reg       <= window[K-2:0];
            tail_cnt_reg <= tail_cnt_reg - CW'(1);
            last_reg     <= tail_final;
            if (tail_final) begin
                state_reg <= RUN;
            end
        end else if (code.ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign code.valid = valid_reg;
    assign code.data  = data_reg;
    assign code.last  = last_reg;
endmodule
